// File: rtl/float_mac_acc.sv
// float_mac_acc: serial float multiply-accumulate, LEN products per result.
// Define FLOAT_MAC_BIAS_EN to add a bias port preloaded into the accumulator.

module floatMult (
   input  logic [31:0] floatA,
   input  logic [31:0] floatB,
   output logic [31:0] product
);
   logic              sgn;
   logic [47:0]       ma;
   logic [47:0]       mb;
   logic [47:0]       p;
   logic signed [9:0] e;
   logic [23:0]       m;
   logic              g;
   logic              st;
   logic [24:0]       r;

   always_comb begin
      sgn = floatA[31] ^ floatB[31];
      ma  = {24'd0, 1'b1, floatA[22:0]};
      mb  = {24'd0, 1'b1, floatB[22:0]};
      p   = ma * mb;
      e   = $signed({2'b00, floatA[30:23]})
          + $signed({2'b00, floatB[30:23]})
          - 10'sd127;
      if (p[47]) begin
         m  = p[47:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 10'sd1;
      end else begin
         m  = p[46:23];
         g  = p[22];
         st = |p[21:0];
      end
      // round to nearest, ties to even
      r = {1'b0, m} + {24'd0, g & (st | m[0])};
      if (r[24])
         e = e + 10'sd1;
      if (floatA[30:23] == 8'd0 || floatB[30:23] == 8'd0)
         product = 32'h0;
      else if (e >= 10'sd255)
         product = {sgn, 8'hff, 23'd0};
      else if (e <= 10'sd0)
         product = 32'h0;
      else if (r[24])
         product = {sgn, e[7:0], r[23:1]};
      else
         product = {sgn, e[7:0], r[22:0]};
   end
endmodule

module floatAdd (
   input  logic [31:0] floatA,
   input  logic [31:0] floatB,
   output logic [31:0] sum
);
   logic [31:0]       big;
   logic [31:0]       sml;
   logic [7:0]        diff;
   logic [26:0]       bm;
   logic [26:0]       sm;
   logic [26:0]       sh;
   logic [26:0]       mask;
   logic [27:0]       raw;
   logic [26:0]       nrm;
   logic [4:0]        lz;
   logic              found;
   logic signed [9:0] e;
   logic [24:0]       r;

   always_comb begin
      if (floatB[30:0] > floatA[30:0]) begin
         big = floatB;
         sml = floatA;
      end else begin
         big = floatA;
         sml = floatB;
      end
      diff = big[30:23] - sml[30:23];
      bm   = {1'b1, big[22:0], 3'b000};
      sm   = {1'b1, sml[22:0], 3'b000};
      if (diff >= 8'd27) begin
         sh   = 27'd0;
         mask = {27{1'b1}};
      end else begin
         sh   = sm >> diff;
         mask = (27'd1 << diff) - 27'd1;
      end
      // bits shifted out collapse into the sticky bit
      sh[0] = sh[0] | (|(sm & mask));
      if (big[31] == sml[31])
         raw = {1'b0, bm} + {1'b0, sh};
      else
         raw = {1'b0, bm} - {1'b0, sh};
      e     = $signed({2'b00, big[30:23]});
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && raw[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
         end
      end
      if (raw[27]) begin
         nrm = {raw[27:2], raw[1] | raw[0]};
         e   = e + 10'sd1;
      end else begin
         nrm = raw[26:0] << lz;
         e   = e - $signed({5'd0, lz});
      end
      r = {1'b0, nrm[26:3]}
        + {24'd0, nrm[2] & (nrm[1] | nrm[0] | nrm[3])};
      if (r[24])
         e = e + 10'sd1;
      if (sml[30:23] == 8'd0)
         sum = (big[30:23] == 8'd0) ? 32'h0 : big;
      else if (raw == 28'd0)
         sum = 32'h0;
      else if (e >= 10'sd255)
         sum = {big[31], 8'hff, 23'd0};
      else if (e <= 10'sd0)
         sum = 32'h0;
      else if (r[24])
         sum = {big[31], e[7:0], r[23:1]};
      else
         sum = {big[31], e[7:0], r[22:0]};
   end
endmodule

module float_mac_acc #(
   parameter int LEN = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] floatA,
   input  logic [31:0] floatB,
`ifdef FLOAT_MAC_BIAS_EN
   input  logic [31:0] bias,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [7:0] LEN8 = 8'(LEN);

   state_t      state;
   logic [7:0]  count;
   logic [31:0] acc;
   logic [31:0] prod_reg;
   logic        prod_vld;
   logic [31:0] prod;
   logic [31:0] sum;
   logic        take;

   assign take   = in_valid & in_ready;
   assign result = acc;

   floatMult u_mult (
      .floatA (floatA),
      .floatB (floatB),
      .product(prod)
   );

   floatAdd u_add (
      .floatA(acc),
      .floatB(prod_reg),
      .sum   (sum)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= 8'd0;
         acc       <= 32'h0;
         prod_reg  <= 32'h0;
         prod_vld  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         prod_vld <= take;
         if (take)
            prod_reg <= prod;
         if (prod_vld)
            acc <= sum;
         case (state)
            IDLE: begin
               if (take) begin
                  state    <= ACCUM;
                  count    <= 8'd1;
                  busy     <= 1'b1;
                  in_ready <= (8'd1 < LEN8);
`ifdef FLOAT_MAC_BIAS_EN
                  acc      <= bias;
`endif
               end
            end
            ACCUM: begin
               if (take) begin
                  count    <= count + 8'd1;
                  in_ready <= ((count + 8'd1) < LEN8);
               end
               // last product has drained into acc
               if (count == LEN8 && !prod_vld) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  count     <= 8'd0;
                  acc       <= 32'h0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_float_mac_acc.sv
// tb_float_mac_acc: directed and randomized checks of float_mac_acc for
// several LEN values against an exact fixed-point model of the sums.

module tb_float_mac_acc;
   localparam int N = 5;

   function automatic int len_of(input int g);
      case (g)
         0:       return 9;
         1:       return 3;
         2:       return 2;
         3:       return 4;
         default: return 1;
      endcase
   endfunction

`ifdef FLOAT_MAC_BIAS_EN
   localparam bit HAS_BIAS = 1'b1;
   logic [31:0] bias_v = 32'h3F800000;
`else
   localparam bit HAS_BIAS = 1'b0;
`endif
   localparam longint BIASQ = HAS_BIAS ? 64'sd16 : 64'sd0;

   logic        clk = 1'b0;
   logic        reset;
   logic        iv;
   logic [31:0] fa;
   logic [31:0] fb;
   logic        ordy;
   int          sel;

   logic        inr [N];
   logic        ov  [N];
   logic        bsy [N];
   logic [31:0] res [N];

   logic [31:0] va [16];
   logic [31:0] vb [16];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      float_mac_acc #(.LEN(len_of(g))) u_dut (
         .clk      (clk),
         .reset    (reset),
         .in_valid (iv && (sel == g)),
         .in_ready (inr[g]),
         .floatA   (fa),
         .floatB   (fb),
`ifdef FLOAT_MAC_BIAS_EN
         .bias     (bias_v),
`endif
         .out_valid(ov[g]),
         .out_ready(ordy),
         .result   (res[g]),
         .busy     (bsy[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // exact single-precision encoding of v/16 (|v| < 2^24)
   function automatic logic [31:0] f16(input longint v);
      longint      m;
      int          p;
      logic [31:0] f;
      if (v == 0)
         return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 40; i++)
         if (m >= (longint'(1) << i))
            p = i;
      f[31]    = (v < 0);
      f[30:23] = 8'(p - 4 + 127);
      f[22:0]  = 23'(m << (23 - p));
      return f;
   endfunction

   // operand = k * 2^s / 4, returned in quarter units
   task automatic rand_op(output logic [31:0] bits, output longint q);
      int k;
      int s;
      k    = int'($urandom_range(0, 30)) - 15;
      s    = int'($urandom_range(0, 4));
      q    = longint'(k) <<< s;
      bits = f16(q * 4);
   endtask

   task automatic feed(input int s, input int n, input int mode);
      int   i;
      int   t;
      logic rdy;
      i   = 0;
      t   = 0;
      sel = s;
      while (i < n && t < 500) begin
         if (mode == 0)
            iv = 1'b1;
         else if (mode == 1)
            iv = ((t % 2) == 0);
         else
            iv = 1'($urandom_range(0, 1));
         fa  = va[i];
         fb  = vb[i];
         rdy = inr[s];
         @(posedge clk);
         #1;
         if (iv && rdy)
            i++;
         t++;
      end
      iv = 1'b0;
      fa = $urandom;
      fb = $urandom;
      if (i < n)
         chk("feed_timeout", i, n);
   endtask

   // entered 1 time unit after the edge of the last accept
   task automatic complete(input int s, input logic [31:0] exp,
                           input string tag);
      chk({tag, "_rdy_t0"}, inr[s], 1'b0);
      chk({tag, "_ov_t0"}, ov[s], 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_ov_t1"}, ov[s], 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_ov_t2"}, ov[s], 1'b1);
      chk({tag, "_res"}, res[s], exp);
      chk({tag, "_busy"}, bsy[s], 1'b1);
   endtask

   task automatic drain(input int s, input logic [31:0] exp, input int hold,
                        input string tag);
      sel = s;
      for (int c = 0; c < hold; c++) begin
         iv = 1'b1;
         fa = $urandom;
         fb = $urandom;
         @(posedge clk);
         #1;
         chk({tag, "_hold_ov"}, ov[s], 1'b1);
         chk({tag, "_hold_res"}, res[s], exp);
         chk({tag, "_hold_rdy"}, inr[s], 1'b0);
      end
      iv   = 1'b0;
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      chk({tag, "_idle_ov"}, ov[s], 1'b0);
      chk({tag, "_idle_rdy"}, inr[s], 1'b1);
      chk({tag, "_idle_busy"}, bsy[s], 1'b0);
      chk({tag, "_idle_res"}, res[s], 32'h0);
   endtask

   task automatic chk_reset(input string tag);
      for (int g = 0; g < N; g++) begin
         chk({tag, "_rdy"}, inr[g], 1'b1);
         chk({tag, "_ov"}, ov[g], 1'b0);
         chk({tag, "_busy"}, bsy[g], 1'b0);
         chk({tag, "_res"}, res[g], 32'h0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      longint sum;
      longint qa;
      longint qb;
      int     s;
      int     n;

      reset = 1'b1;
      iv    = 1'b0;
      ordy  = 1'b0;
      sel   = 0;
      fa    = 32'h0;
      fb    = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_reset("reset");

      // nine 1.0*1.0 back to back
      for (int i = 0; i < 9; i++) begin
         va[i] = 32'h3F800000;
         vb[i] = 32'h3F800000;
      end
      feed(0, 9, 0);
      complete(0, HAS_BIAS ? 32'h41200000 : 32'h41100000, "ones9");
      drain(0, HAS_BIAS ? 32'h41200000 : 32'h41100000, 0, "ones9");

      // 2*3 + 1*2 + 0*3, zero operand
      va[0] = 32'h40000000; vb[0] = 32'h40400000;
      va[1] = 32'h3F800000; vb[1] = 32'h40000000;
      va[2] = 32'h00000000; vb[2] = 32'h40400000;
      feed(1, 3, 0);
      complete(1, HAS_BIAS ? 32'h41100000 : 32'h41000000, "len3");
      drain(1, HAS_BIAS ? 32'h41100000 : 32'h41000000, 0, "len3");

      // 1.5*2 + -0.5*3 held five cycles in DONE
      va[0] = 32'h3FC00000; vb[0] = 32'h40000000;
      va[1] = 32'hBF000000; vb[1] = 32'h40400000;
      feed(2, 2, 0);
      complete(2, HAS_BIAS ? 32'h40200000 : 32'h3FC00000, "hold");
      drain(2, HAS_BIAS ? 32'h40200000 : 32'h3FC00000, 5, "hold");

      // bias case: 1*1 + 1*1
      va[0] = 32'h3F800000; vb[0] = 32'h3F800000;
      va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
      feed(2, 2, 0);
      complete(2, HAS_BIAS ? 32'h40400000 : 32'h40000000, "len2");
      drain(2, HAS_BIAS ? 32'h40400000 : 32'h40000000, 1, "len2");

      // reset after four accepts discards the partial sum
      for (int i = 0; i < 9; i++) begin
         va[i] = 32'h3F800000;
         vb[i] = 32'h3F800000;
      end
      feed(0, 4, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_reset("midreset");
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         chk("midreset_quiet", ov[0], 1'b0);
      end
      feed(0, 9, 0);
      complete(0, HAS_BIAS ? 32'h41200000 : 32'h41100000, "fresh9");
      drain(0, HAS_BIAS ? 32'h41200000 : 32'h41100000, 0, "fresh9");

      // gapped 1*2 four times
      for (int i = 0; i < 4; i++) begin
         va[i] = 32'h3F800000;
         vb[i] = 32'h40000000;
      end
      feed(3, 4, 1);
      complete(3, HAS_BIAS ? 32'h41100000 : 32'h41000000, "gaps");
      drain(3, HAS_BIAS ? 32'h41100000 : 32'h41000000, 0, "gaps");

      // single product: 3 * -2.5
      va[0] = 32'h40400000; vb[0] = 32'hC0200000;
      feed(4, 1, 0);
      complete(4, HAS_BIAS ? 32'hC0D00000 : 32'hC0F00000, "len1");
      drain(4, HAS_BIAS ? 32'hC0D00000 : 32'hC0F00000, 2, "len1");

      // randomized transactions against the fixed-point model
      for (int t = 0; t < 40; t++) begin
         s   = int'($urandom_range(0, N - 1));
         n   = len_of(s);
         sum = BIASQ;
         for (int i = 0; i < n; i++) begin
            rand_op(va[i], qa);
            rand_op(vb[i], qb);
            sum += qa * qb;
         end
         feed(s, n, int'($urandom_range(0, 2)));
         complete(s, f16(sum), "rand");
         drain(s, f16(sum), int'($urandom_range(0, 3)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
